// File: rtl/pmu_pkg.sv
// Shared types and constants for the PMU counter controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmu_pkg;

  // Controller state; the code is also reported in the status word.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_FROZEN = 2'd3
  } pmu_state_e;

  // Bit positions inside the control write word.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_FREEZE = 2;
  localparam int CTRL_IRQEN  = 3;

  // Field offsets inside the status read word.
  localparam int STS_EN        = 0;
  localparam int STS_BUSY      = 1;
  localparam int STS_FREEZE    = 2;
  localparam int STS_IRQEN     = 3;
  localparam int STS_STATE_LSB = 4;
  localparam int STS_STATE_W   = 4;
  localparam int STS_OVF_LSB   = 32;
  localparam int STS_OVF_W     = 32;

  // The status word sits directly after the last counter in the read map.
  function automatic int unsigned status_addr(input int unsigned n_counters);
    return n_counters;
  endfunction

endpackage

// File: rtl/pmu_event_counter.sv
// Single PMU event counter with clear, increment and hold.
// Latency: count updates on the edge after inc/clr; wrap is combinational.
// Backpressure: none; inc is accepted every cycle, clr wins over inc.
module pmu_event_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Counter register: clear beats increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

  // An increment at all-ones rolls over to zero this edge; a clear masks it.
  assign wrap = inc & ~clr & (&cnt_q);

endmodule

// File: rtl/pmu_counter_ctrl.sv
// PMU event-counter bank: control register, start/stop/sweep-clear/freeze FSM, read mux, irq.
// Latency: control fields stored 1 cycle after write; reads combinational; irq 1 cycle after ovf.
// Backpressure: none; writes always accepted, busy_o flags an in-progress clear sweep.
module pmu_counter_ctrl
  import pmu_pkg::*;
#(
  parameter int N_COUNTERS = 23,
  parameter int CNT_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [N_COUNTERS-1:0] events_i,
  input  logic [ADDR_WIDTH-1:0] counter_address_in,
  output logic [CNT_WIDTH-1:0]  counter_data_out,
  input  logic                  cfg_wr_en_i,
  input  logic [CNT_WIDTH-1:0]  cfg_wr_data_i,
  output logic                  busy_o,
  output logic                  irq_o
);

  localparam int CIDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(N_COUNTERS - 1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(status_addr(N_COUNTERS));

  pmu_state_e state_q, state_d;

  logic                  en_q;
  logic                  freeze_q;
  logic                  irq_en_q;
  logic                  irq_q;
  logic [N_COUNTERS-1:0] ovf_q;
  logic [CIDX_W-1:0]     clr_idx_q;

  logic [N_COUNTERS-1:0] inc;
  logic [N_COUNTERS-1:0] clr_sel;
  logic [N_COUNTERS-1:0] wrap;
  logic [CNT_WIDTH-1:0]  cnt [N_COUNTERS];
  logic [CNT_WIDTH-1:0]  status_w;
  logic [CNT_WIDTH-1:0]  rd_dat;
  logic                  busy;

  logic clr_wr;
  logic any_wrap;
  logic last_idx;
  logic freeze_entry;

  // Upper control bits carry no meaning; collected here so they are not flagged.
  logic unused_wr_bits;
  assign unused_wr_bits = ^cfg_wr_data_i[CNT_WIDTH-1:4];

  assign clr_wr       = cfg_wr_en_i & cfg_wr_data_i[CTRL_CLR];
  assign any_wrap     = |wrap;
  assign last_idx     = (clr_idx_q == LAST_IDX);
  assign freeze_entry = (state_q == ST_RUN) && (state_d == ST_FROZEN);

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a clr write outranks everything, including a freeze wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_wr) begin
          state_d = ST_CLEAR;
        end else if (en_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_wr) begin
          state_d = ST_CLEAR;
        end else if (freeze_q && any_wrap) begin
          state_d = ST_FROZEN;
        end else if (!en_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_wr) begin
          state_d = ST_CLEAR;
        end else if (last_idx) begin
          state_d = en_q ? ST_RUN : ST_IDLE;
        end
      end
      ST_FROZEN: begin
        if (clr_wr) begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: per-counter increment/clear selects and the busy flag.
  always_comb begin
    inc     = '0;
    clr_sel = '0;
    busy    = 1'b0;
    case (state_q)
      ST_RUN: begin
        inc = events_i;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        for (int k = 0; k < N_COUNTERS; k++) begin
          if (CIDX_W'(k) == clr_idx_q) begin
            clr_sel[k] = 1'b1;
          end
          // Only counters behind the sweep pointer resume counting.
          if (en_q && (CIDX_W'(k) < clr_idx_q)) begin
            inc[k] = events_i[k];
          end
        end
      end
      default: ;
    endcase
  end

  // Sweep pointer: restarts on any clr write, walks once through the bank.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      clr_idx_q <= '0;
    end else if (clr_wr) begin
      clr_idx_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_idx_q <= last_idx ? '0 : clr_idx_q + 1'b1;
    end else begin
      clr_idx_q <= '0;
    end
  end

  // Control fields; entering FROZEN drops en so a later clear does not auto-run.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      en_q     <= 1'b0;
      freeze_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (cfg_wr_en_i) begin
        en_q     <= cfg_wr_data_i[CTRL_EN];
        freeze_q <= cfg_wr_data_i[CTRL_FREEZE];
        irq_en_q <= cfg_wr_data_i[CTRL_IRQEN];
      end
      if (freeze_entry) begin
        en_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flags, only cleared by the sweep or reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q | wrap) & ~clr_sel;
    end
  end

  // Registered interrupt level.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & (|ovf_q);
    end
  end

  for (genvar k = 0; k < N_COUNTERS; k++) begin : gen_cnt
    pmu_event_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk  (S_AXI_ACLK),
      .rst  (S_AXI_ARESET),
      .inc  (inc[k]),
      .clr  (clr_sel[k]),
      .cnt  (cnt[k]),
      .wrap (wrap[k])
    );
  end

  // Status word assembly.
  always_comb begin
    status_w                                  = '0;
    status_w[STS_EN]                          = en_q;
    status_w[STS_BUSY]                        = busy;
    status_w[STS_FREEZE]                      = freeze_q;
    status_w[STS_IRQEN]                       = irq_en_q;
    status_w[STS_STATE_LSB +: STS_STATE_W]    = {2'b00, state_q};
    status_w[STS_OVF_LSB +: N_COUNTERS]       = ovf_q;
  end

  // Read mux: counters, then status, everything else reads zero.
  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      if (counter_address_in == ADDR_WIDTH'(k)) begin
        rd_dat = cnt[k];
      end
    end
    if (counter_address_in == STATUS_ADDR) begin
      rd_dat = status_w;
    end
  end

  assign counter_data_out = rd_dat;
  assign busy_o           = busy;
  assign irq_o            = irq_q;

endmodule
